mem_stage_cache_2way: RTL and testbench
=======================================

// Module: mem_stage_cache_2way
// PURPOSE
// - Parametrised memory stage with 2-way set-associative, write-through, no-write-allocate cache.
// - Sits between the EXE/MEM pipeline register and a wide-line SRAM controller.
// - Freezes the pipeline through 'ready' on misses and writes.
// - Passes the PC through unchanged.
// PARAMETERS
// - ADDR_W      32    address width (pc, alu_res, sram_address)
// - WORD_W      32    data word width
// - LINE_WORDS  2     words per cache line, power of 2 >= 2; backend line width = WORD_W*LINE_WORDS
// - SETS        64    sets per way, power of 2
// - BASE_ADDR   1024  subtracted from alu_res before address decode
// PORTS
// - clk            in   1                  clock, rising edge
// - rst            in   1                  synchronous reset, active-high
// - pc_in          in   ADDR_W             PC from the previous stage
// - pc             out  ADDR_W             = pc_in (combinational)
// - mem_r_en       in   1                  load request
// - mem_w_en       in   1                  store request
// - alu_res        in   ADDR_W             byte address
// - val_rm         in   WORD_W             store data
// - memory_out     out  WORD_W             load data; 0 when no load completes this cycle
// - ready          out  1                  1 = access complete / idle; 0 = freeze pipeline
// - sram_read_en   out  1                  line-fill request to backend
// - sram_write_en  out  1                  word write request to backend
// - sram_address   out  ADDR_W             backend address (already BASE_ADDR-relative)
// - sram_write_data out WORD_W             backend write word
// - sram_read_data in   WORD_W*LINE_WORDS  backend line, word 0 in LSBs
// - sram_ready     in   1                  backend done pulse, 1 cycle
// BEHAVIOUR
// - Address decode (ea = alu_res - BASE_ADDR, mod 2^ADDR_W):
//   - [1:0] byte offset, ignored
//   - next log2(LINE_WORDS) bits: word select
//   - next log2(SETS) bits: index
//   - remaining bits: tag
// - Per set: valid and tag per way, 1-bit LRU (points at the victim way).
// - Hit: matching valid tag in either way. If both ways hit (illegal), way 0 wins.
// - Request decode: mem_w_en has priority over mem_r_en when both are high; the access is treated as a store.
// - FSM states IDLE, FILL, WRITE. Reset -> IDLE.
// - IDLE, no request: ready=1, memory_out=0, both backend enables 0.
// - IDLE, read hit:
//   - same cycle: ready=1, memory_out = hit word (0 cycles added)
//   - LRU <= other way
// - IDLE, read miss:
//   - ready=0
//   - next state FILL; latch line address = ea with the word-select and byte bits cleared
// - FILL:
//   - sram_read_en=1, address held stable, ready=0 until sram_ready
//   - in the sram_ready cycle: memory_out = requested word of sram_read_data, ready=1
//   - line written into the victim way: invalid way first, way 0 if both ways are invalid, otherwise the LRU way
//   - valid set, tag stored, LRU <= the other way; next state IDLE
// - IDLE, write:
//   - ready=0; next state WRITE; latch ea and val_rm
//   - on hit, the cached word is updated and LRU <= other way
//   - on miss, cache contents are unchanged (no allocate)
// - WRITE: sram_write_en=1, address/data held stable, ready=0 until sram_ready. In that cycle ready=1; next state IDLE.
// - Backend contract:
//   - sram_read_en and sram_write_en are never high together
//   - each is deasserted in the cycle after sram_ready (state back in IDLE)
//   - sram_ready seen while in IDLE is ignored
// - Request fields must be held stable by the pipeline (frozen) while ready=0.
// - rst in any state, including mid-FILL/WRITE:
//   - next edge: all valid bits=0, all LRU bits=0, FSM=IDLE, backend enables=0
//   - a backend transaction in flight is abandoned
// CONFIGURATION
// - CACHE_STATS_EN defined:
//   - adds outputs hit_count[31:0] and miss_count[31:0], both 0 on rst
//   - +1 per read hit (IDLE cycle) or per read miss (IDLE->FILL transition); saturate at 2^32-1
//   - writes are not counted
// - CACHE_STATS_EN undefined: the ports and counters do not exist; behaviour is otherwise identical.
// TESTING
// - rst, then read alu_res=1024, sram_read_data={32'hB,32'hA} after 3 cycles:
//   ready=0 for 3 cycles, then ready=1 with memory_out=A and sram_address=0.
// - Read alu_res=1028 next: same-cycle hit, memory_out=B, ready=1, no sram_read_en.
// - Write val_rm=5 to 1024: sram_write_en with address 0, data 5, ready=0 until sram_ready.
//   A following read of 1024 hits and returns 5.
// - Reads at ea 0, 512, 1024 (same set, SETS=64, LINE_WORDS=2):
//   the third access evicts the ea-0 line; re-reading 512 hits, re-reading 0 misses.
// - Assert rst mid-FILL: next cycle FSM=IDLE, sram_read_en=0; re-reading the same address misses.
// - With CACHE_STATS_EN, the sequence miss, hit, hit, write gives hit_count=2, miss_count=1.

Source files
------------

// File: rtl/mem_stage_cache_2way.sv
// Memory stage with a 2-way set-associative, write-through, no-write-allocate cache in front of a line SRAM.
// Optional hit/miss counters are compiled in when CACHE_STATS_EN is defined.
module mem_stage_cache_2way #(
  parameter int ADDR_W     = 32,
  parameter int WORD_W     = 32,
  parameter int LINE_WORDS = 2,
  parameter int SETS       = 64,
  parameter int BASE_ADDR  = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_W-1:0]            pc_in,
  output logic [ADDR_W-1:0]            pc,
  input  logic                         mem_r_en,
  input  logic                         mem_w_en,
  input  logic [ADDR_W-1:0]            alu_res,
  input  logic [WORD_W-1:0]            val_rm,
  output logic [WORD_W-1:0]            memory_out,
  output logic                         ready,
  output logic                         sram_read_en,
  output logic                         sram_write_en,
  output logic [ADDR_W-1:0]            sram_address,
  output logic [WORD_W-1:0]            sram_write_data,
  input  logic [WORD_W*LINE_WORDS-1:0] sram_read_data,
  input  logic                         sram_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]                  hit_count,
  output logic [31:0]                  miss_count
`endif
);

  localparam int WSEL_W = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - 2 - WSEL_W - IDX_W;
  localparam int LINE_W = WORD_W * LINE_WORDS;
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((2 ** (2 + WSEL_W)) - 1);

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [WORD_W-1:0]   wdata_q;
  logic [WSEL_W-1:0]   wsel_q;
  logic                rd_en_q;
  logic                wr_en_q;
  logic [SETS-1:0]     valid0_q;
  logic [SETS-1:0]     valid1_q;
  logic [SETS-1:0]     lru_q;
  logic [TAG_W-1:0]    tag0_q  [SETS];
  logic [TAG_W-1:0]    tag1_q  [SETS];
  logic [LINE_W-1:0]   data0_q [SETS];
  logic [LINE_W-1:0]   data1_q [SETS];

  logic [ADDR_W-1:0]   ea;
  logic [WSEL_W-1:0]   wsel;
  logic [IDX_W-1:0]    idx;
  logic [TAG_W-1:0]    tag;
  logic [IDX_W-1:0]    f_idx;
  logic [TAG_W-1:0]    f_tag;
  logic                hit0, hit1, hit;
  logic [LINE_W-1:0]   hit_line;
  logic [LINE_W-1:0]   upd_line;
  logic [WORD_W-1:0]   hit_word;
  logic [WORD_W-1:0]   fill_word;
  logic                idle, is_wr, is_rd;
  logic                rd_hit, rd_miss, wr_req, fill_done, wr_done;
  logic                victim_way;

  assign pc   = pc_in;
  assign ea   = alu_res - BASE;
  assign wsel = ea[2 +: WSEL_W];
  assign idx  = ea[2 + WSEL_W +: IDX_W];
  assign tag  = ea[ADDR_W-1 -: TAG_W];

  assign f_idx = addr_q[2 + WSEL_W +: IDX_W];
  assign f_tag = addr_q[ADDR_W-1 -: TAG_W];

  assign hit0     = valid0_q[idx] && (tag0_q[idx] == tag);
  assign hit1     = valid1_q[idx] && (tag1_q[idx] == tag);
  assign hit      = hit0 || hit1;
  assign hit_line = hit0 ? data0_q[idx] : data1_q[idx];

  assign idle      = (state_q == IDLE);
  assign is_wr     = mem_w_en;
  assign is_rd     = mem_r_en && !mem_w_en;
  assign rd_hit    = idle && is_rd && hit;
  assign rd_miss   = idle && is_rd && !hit;
  assign wr_req    = idle && is_wr;
  assign fill_done = (state_q == FILL) && sram_ready;
  assign wr_done   = (state_q == WRITE) && sram_ready;

  // An invalid way is always preferred over evicting a live line.
  assign victim_way = !valid0_q[f_idx] ? 1'b0 :
                      !valid1_q[f_idx] ? 1'b1 : lru_q[f_idx];

  always_comb begin
    hit_word  = '0;
    fill_word = '0;
    upd_line  = hit_line;
    for (int w = 0; w < LINE_WORDS; w++) begin
      if (WSEL_W'(w) == wsel) begin
        hit_word = hit_line[w*WORD_W +: WORD_W];
        upd_line[w*WORD_W +: WORD_W] = val_rm;
      end
      if (WSEL_W'(w) == wsel_q) begin
        fill_word = sram_read_data[w*WORD_W +: WORD_W];
      end
    end
  end

  assign memory_out      = rd_hit ? hit_word : (fill_done ? fill_word : '0);
  assign ready           = idle ? !(wr_req || rd_miss) : (fill_done || wr_done);
  assign sram_read_en    = rd_en_q;
  assign sram_write_en   = wr_en_q;
  assign sram_address    = addr_q;
  assign sram_write_data = wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      wsel_q   <= '0;
      rd_en_q  <= 1'b0;
      wr_en_q  <= 1'b0;
      valid0_q <= '0;
      valid1_q <= '0;
      lru_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (is_wr) begin
            state_q <= WRITE;
            wr_en_q <= 1'b1;
            addr_q  <= ea;
            wdata_q <= val_rm;
            if (hit) lru_q[idx] <= hit0;
          end else if (is_rd) begin
            if (hit) begin
              lru_q[idx] <= hit0;
            end else begin
              state_q <= FILL;
              rd_en_q <= 1'b1;
              addr_q  <= ea & ~LOW_MASK;
              wsel_q  <= wsel;
            end
          end
        end
        FILL: begin
          if (sram_ready) begin
            state_q <= IDLE;
            rd_en_q <= 1'b0;
            if (victim_way) valid1_q[f_idx] <= 1'b1;
            else            valid0_q[f_idx] <= 1'b1;
            lru_q[f_idx] <= !victim_way;
          end
        end
        WRITE: begin
          if (sram_ready) begin
            state_q <= IDLE;
            wr_en_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Line storage carries no reset; the valid bits alone qualify it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (fill_done) begin
        if (victim_way) begin
          data1_q[f_idx] <= sram_read_data;
          tag1_q[f_idx]  <= f_tag;
        end else begin
          data0_q[f_idx] <= sram_read_data;
          tag0_q[f_idx]  <= f_tag;
        end
      end else if (wr_req && hit) begin
        if (hit0) data0_q[idx] <= upd_line;
        else      data1_q[idx] <= upd_line;
      end
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (rd_hit && (hit_count_q != '1))   hit_count_d  = hit_count_q + 32'd1;
    if (rd_miss && (miss_count_q != '1)) miss_count_d = miss_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_mem_stage_cache_2way.sv
// Bench for mem_stage_cache_2way: directed vector table, reset/idle corner sequences, then
// random traffic checked against a recency-list cache model and a flat reference memory.
module tb_mem_stage_cache_2way;

  logic        clk;
  logic        rst;
  logic [31:0] pc_in, pc;
  logic        mem_r_en, mem_w_en;
  logic [31:0] alu_res, val_rm, memory_out;
  logic        ready, sram_read_en, sram_write_en;
  logic [31:0] sram_address, sram_write_data;
  logic [63:0] sram_read_data;
  logic        sram_ready;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  int checks = 0;
  int errors = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  mem_stage_cache_2way dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc(pc),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .alu_res(alu_res), .val_rm(val_rm),
    .memory_out(memory_out), .ready(ready),
    .sram_read_en(sram_read_en), .sram_write_en(sram_write_en),
    .sram_address(sram_address), .sram_write_data(sram_write_data),
    .sram_read_data(sram_read_data), .sram_ready(sram_ready)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference memory (what a correct design writes) and backend memory (what the DUT wrote).
  logic [31:0] ref_mem  [logic [31:0]];
  logic [31:0] sram_mem [logic [31:0]];

  // Cache model: per set, the two most recently used line numbers (MRU first).
  logic [28:0] mru_line [64];
  logic [28:0] lru_line [64];
  bit          mru_v    [64];
  bit          lru_v    [64];

  function automatic logic [31:0] init_word(input logic [31:0] widx);
    return (widx * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] widx);
    if (ref_mem.exists(widx)) return ref_mem[widx];
    return init_word(widx);
  endfunction

  function automatic logic [31:0] sram_word(input logic [31:0] widx);
    if (sram_mem.exists(widx)) return sram_mem[widx];
    return init_word(widx);
  endfunction

  function automatic bit model_hit(input logic [28:0] line);
    int s;
    s = int'(line[5:0]);
    return (mru_v[s] && mru_line[s] == line) || (lru_v[s] && lru_line[s] == line);
  endfunction

  function automatic void model_touch(input logic [28:0] line);
    int s;
    s = int'(line[5:0]);
    if (mru_v[s] && mru_line[s] == line) return;
    if (lru_v[s] && lru_line[s] == line) begin
      lru_line[s] = mru_line[s];
      mru_line[s] = line;
      return;
    end
    lru_line[s] = mru_line[s];
    lru_v[s]    = mru_v[s];
    mru_line[s] = line;
    mru_v[s]    = 1'b1;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 64; s++) begin
      mru_v[s] = 1'b0;
      lru_v[s] = 1'b0;
    end
    exp_hits   = 0;
    exp_misses = 0;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One pipeline access: drive at negedge, check 1ns later, play the backend for 'lat' cycles.
  task automatic access(input bit w, input bit r_too, input logic [31:0] a, input logic [31:0] d,
                        input int lat, input bit exp_hit, input logic [31:0] exp_data);
    logic [31:0] ea, pcv, wb;
    bit          mh;
    ea  = a - 32'd1024;
    pcv = $urandom;
    mh  = model_hit(ea[31:3]);
    @(negedge clk);
    mem_w_en   = w;
    mem_r_en   = w ? r_too : 1'b1;
    alu_res    = a;
    val_rm     = d;
    pc_in      = pcv;
    sram_ready = 1'b0;
    #1;
    check("pc_pass", pc, pcv);
    check("idle_be_en", {sram_read_en, sram_write_en}, 2'b00);
    if (!w && exp_hit) begin
      check("hit_ready", ready, 1'b1);
      check("hit_data", memory_out, exp_data);
    end else begin
      check("req_ready", ready, 1'b0);
      check("req_dout", memory_out, 32'h0);
      for (int c = 1; c <= lat; c++) begin
        @(negedge clk);
        if (c == lat) begin
          sram_ready = 1'b1;
          if (w) begin
            sram_mem[sram_address >> 2] = sram_write_data;
          end else begin
            wb = sram_address >> 2;
            wb[0] = 1'b0;
            sram_read_data = {sram_word(wb | 32'h1), sram_word(wb)};
          end
        end
        #1;
        check("be_en", {sram_read_en, sram_write_en}, w ? 2'b01 : 2'b10);
        check("be_addr", sram_address, w ? ea : (ea & ~32'h7));
        if (w) check("be_wdata", sram_write_data, d);
        check("be_ready", ready, c == lat);
        check("be_dout", memory_out, (!w && c == lat) ? exp_data : 32'h0);
      end
    end
    if (w) begin
      ref_mem[ea >> 2] = d;
      if (mh) model_touch(ea[31:3]);
    end else begin
      if (mh) exp_hits++;
      else    exp_misses++;
      model_touch(ea[31:3]);
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    mem_r_en   = 1'b0;
    mem_w_en   = 1'b0;
    sram_ready = 1'b0;
  endtask

  typedef struct {
    bit          w;
    logic [31:0] addr;
    logic [31:0] data;
    int          lat;
    bit          hit;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic [31:0] ea, a;
    bit          w, rt, h;

    rst = 1'b1; pc_in = '0; mem_r_en = 1'b0; mem_w_en = 1'b0; alu_res = '0; val_rm = '0;
    sram_read_data = '0; sram_ready = 1'b0;
    model_reset();
    ref_mem[0]  = 32'hA;  ref_mem[1]  = 32'hB;
    sram_mem[0] = 32'hA;  sram_mem[1] = 32'hB;

    // ea 0, 512 and 1024 all map to set 0 with distinct tags.
    tbl[0] = '{1'b0, 32'd1024, 32'd0, 3, 1'b0, 32'hA};
    tbl[1] = '{1'b0, 32'd1028, 32'd0, 1, 1'b1, 32'hB};
    tbl[2] = '{1'b1, 32'd1024, 32'd5, 2, 1'b0, 32'd0};
    tbl[3] = '{1'b0, 32'd1024, 32'd0, 1, 1'b1, 32'd5};
    tbl[4] = '{1'b0, 32'd1536, 32'd0, 2, 1'b0, init_word(32'd128)};
    tbl[5] = '{1'b0, 32'd2048, 32'd0, 1, 1'b0, init_word(32'd256)};
    tbl[6] = '{1'b0, 32'd1536, 32'd0, 1, 1'b1, init_word(32'd128)};
    tbl[7] = '{1'b0, 32'd1024, 32'd0, 4, 1'b0, 32'd5};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ready", ready, 1'b1);
    check("rst_dout", memory_out, 32'h0);
    check("rst_be_en", {sram_read_en, sram_write_en}, 2'b00);

    for (int i = 0; i < 8; i++)
      access(tbl[i].w, 1'b0, tbl[i].addr, tbl[i].data, tbl[i].lat, tbl[i].hit, tbl[i].exp);

    // A stray backend pulse while idle must change nothing.
    go_idle();
    sram_ready = 1'b1;
    #1;
    check("stray_ready", ready, 1'b1);
    check("stray_dout", memory_out, 32'h0);
    @(negedge clk);
    sram_ready = 1'b0;
    #1;
    check("stray_be_en", {sram_read_en, sram_write_en}, 2'b00);
    access(1'b0, 1'b0, 32'd1536, 32'd0, 1, 1'b1, init_word(32'd128));

    // Reset in the middle of a line fill abandons it and empties the cache.
    @(negedge clk);
    mem_r_en = 1'b1; mem_w_en = 1'b0; alu_res = 32'd1064;
    #1;
    check("mf_req_ready", ready, 1'b0);
    @(negedge clk);
    #1;
    check("mf_fill_en", sram_read_en, 1'b1);
    @(negedge clk);
    rst = 1'b1; mem_r_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mf_rst_be_en", {sram_read_en, sram_write_en}, 2'b00);
    check("mf_rst_ready", ready, 1'b1);
    model_reset();
    access(1'b0, 1'b0, 32'd1064, 32'd0, 2, 1'b0, ref_word(32'd10));
    access(1'b0, 1'b0, 32'd1536, 32'd0, 2, 1'b0, ref_word(32'd128));

    for (int i = 0; i < 300; i++) begin
      w  = ($urandom_range(0, 3) == 0);
      rt = 1'($urandom_range(0, 1));
      ea = ($urandom_range(0, 5) << 9) | ($urandom_range(0, 3) << 3) |
           ($urandom_range(0, 1) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) ea = ea | 32'hFFFF_0000;
      a = ea + 32'd1024;
      h = model_hit(ea[31:3]);
      access(w, rt, a, $urandom, $urandom_range(1, 4), h, ref_word(ea >> 2));
    end
    go_idle();

`ifdef CACHE_STATS_EN
    #1;
    check("stat_hits", hit_count, 32'(exp_hits));
    check("stat_misses", miss_count, 32'(exp_misses));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
